// File: rtl/dispenser_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispenser_pkg : FSM state encoding and default parameters for the dispenser
// Revision      : 1.0
// ---------------------------------------------------------------------------
package dispenser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_DELIVER  = 2'd2,
      ST_REFUND   = 2'd3
   } state_e;

   localparam int DEF_NUM_DRINKS  = 4;
   localparam int DEF_NUM_STAGES  = 5;
   localparam int DEF_CREDIT_W    = 8;
   localparam int DEF_STAGE_TICKS = 2;

endpackage
`default_nettype wire

// File: rtl/drink_dispenser_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// drink_dispenser_ctrl_if : front-end requests and valve/LED-side results
// Revision                : 1.0
// ---------------------------------------------------------------------------
interface drink_dispenser_ctrl_if
   import dispenser_pkg::*;
#(
   parameter int NUM_DRINKS = DEF_NUM_DRINKS,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int CREDIT_W   = DEF_CREDIT_W,
   parameter int SEL_W      = $clog2(NUM_DRINKS)
);
   logic                           coin_valid;
   logic [CREDIT_W-1:0]            coin_value;
   logic                           select_valid;
   logic [SEL_W-1:0]               select_id;
   logic                           cancel;
   logic                           tick;
   logic [NUM_DRINKS*CREDIT_W-1:0] price;
   logic [NUM_DRINKS*NUM_STAGES-1:0] recipe;
   logic [CREDIT_W-1:0]            credit;
   logic [NUM_STAGES-1:0]          stage_on;
   logic                           busy;
   logic                           product;
   logic                           change_valid;
   logic [CREDIT_W-1:0]            change_value;
   logic                           coin_reject;
   logic                           deny;
   logic [1:0]                     state_o;

   modport master (
      output coin_valid, coin_value, select_valid, select_id, cancel, tick, price, recipe,
      input  credit, stage_on, busy, product, change_valid, change_value, coin_reject,
             deny, state_o
   );

   modport slave (
      input  coin_valid, coin_value, select_valid, select_id, cancel, tick, price, recipe,
      output credit, stage_on, busy, product, change_valid, change_value, coin_reject,
             deny, state_o
   );
endinterface
`default_nettype wire

// File: rtl/dispenser_stage_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dispenser_stage_seq : walks the latched recipe mask one stage at a time
// Revision            : 1.0
// ---------------------------------------------------------------------------
module dispenser_stage_seq
   import dispenser_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_TICKS = DEF_STAGE_TICKS
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  start,
   input  wire logic                  tick,
   input  wire logic [NUM_STAGES-1:0] mask_in,
   output logic      [NUM_STAGES-1:0] stage_on,
   output logic                       done
);
   localparam int TCW  = $clog2(STAGE_TICKS + 1);
   localparam int IDXW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   logic                  active_q, active_d;
   logic [NUM_STAGES-1:0] mask_q, mask_d;
   logic [NUM_STAGES-1:0] stage_on_q, stage_on_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [TCW-1:0]        tcnt_q, tcnt_d;
   logic                  stage_end;

   always_comb begin
      active_d   = active_q;
      mask_d     = mask_q;
      idx_d      = idx_q;
      tcnt_d     = tcnt_q;
      stage_end  = 1'b0;
      done       = 1'b0;
      stage_on_d = '0;
      if (start) begin
         active_d = 1'b1;
         mask_d   = mask_in;
         idx_d    = '0;
         tcnt_d   = '0;
      end else if (active_q) begin
         // A disabled stage still costs exactly one cycle.
         if (!mask_q[idx_q]) begin
            stage_end = 1'b1;
         end else if (tick) begin
            if (tcnt_q == TCW'(STAGE_TICKS - 1)) stage_end = 1'b1;
            else                                 tcnt_d    = tcnt_q + TCW'(1);
         end
         if (stage_end) begin
            tcnt_d = '0;
            if (idx_q == IDXW'(NUM_STAGES - 1)) begin
               active_d = 1'b0;
               done     = 1'b1;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
      end
      if (active_d && mask_d[idx_d]) stage_on_d[idx_d] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q   <= 1'b0;
         mask_q     <= '0;
         idx_q      <= '0;
         tcnt_q     <= '0;
         stage_on_q <= '0;
      end else begin
         active_q   <= active_d;
         mask_q     <= mask_d;
         idx_q      <= idx_d;
         tcnt_q     <= tcnt_d;
         stage_on_q <= stage_on_d;
      end
   end

   assign stage_on = stage_on_q;
endmodule
`default_nettype wire

// File: rtl/drink_dispenser_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// drink_dispenser_ctrl : coin credit, selection check, dispense/refund FSM
// Revision             : 1.0
// ---------------------------------------------------------------------------
module drink_dispenser_ctrl
   import dispenser_pkg::*;
#(
   parameter int NUM_DRINKS  = DEF_NUM_DRINKS,
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int CREDIT_W    = DEF_CREDIT_W,
   parameter int STAGE_TICKS = DEF_STAGE_TICKS
) (
   input wire logic              clk,
   input wire logic              rst,
   drink_dispenser_ctrl_if.slave bus
);
   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic [CREDIT_W-1:0]   change_value_q, change_value_d;
   logic                  busy_q, busy_d;
   logic                  product_q, product_d;
   logic                  change_valid_q, change_valid_d;
   logic                  coin_reject_q, coin_reject_d;
   logic                  deny_q, deny_d;
   logic                  seq_start, seq_done;
   logic [CREDIT_W:0]     coin_sum;
   logic [CREDIT_W-1:0]   sel_price;
   logic [NUM_STAGES-1:0] sel_recipe;
   logic                  sel_in_range;

   // Mux by comparison so an out-of-range id never indexes past the tables.
   always_comb begin
      sel_in_range = 1'b0;
      sel_price    = '0;
      sel_recipe   = '0;
      for (int i = 0; i < NUM_DRINKS; i++) begin
         if (int'(bus.select_id) == i) begin
            sel_in_range = 1'b1;
            sel_price    = bus.price[i*CREDIT_W +: CREDIT_W];
            sel_recipe   = bus.recipe[i*NUM_STAGES +: NUM_STAGES];
         end
      end
   end

   assign coin_sum = {1'b0, credit_q} + {1'b0, bus.coin_value};

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      product_d      = 1'b0;
      change_valid_d = 1'b0;
      change_value_d = '0;
      coin_reject_d  = 1'b0;
      deny_d         = 1'b0;
      seq_start      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cancel) begin
               coin_reject_d = bus.coin_valid;
               if (credit_q != '0) begin
                  change_valid_d = 1'b1;
                  change_value_d = credit_q;
                  credit_d       = '0;
                  state_d        = ST_REFUND;
               end
            end else if (bus.select_valid) begin
               coin_reject_d = bus.coin_valid;
               if (!sel_in_range || credit_q < sel_price || sel_recipe == '0) begin
                  deny_d = 1'b1;
               end else begin
                  credit_d  = credit_q - sel_price;
                  seq_start = 1'b1;
                  state_d   = ST_DISPENSE;
               end
            end else if (bus.coin_valid) begin
               if (coin_sum[CREDIT_W]) coin_reject_d = 1'b1;
               else                    credit_d      = coin_sum[CREDIT_W-1:0];
            end
         end
         ST_DISPENSE: begin
            coin_reject_d = bus.coin_valid;
            if (seq_done) begin
               state_d   = ST_DELIVER;
               product_d = 1'b1;
               if (credit_q != '0) begin
                  change_valid_d = 1'b1;
                  change_value_d = credit_q;
                  credit_d       = '0;
               end
            end
         end
         default: begin
            coin_reject_d = bus.coin_valid;
            state_d       = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_DISPENSE) || (state_d == ST_DELIVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         busy_q         <= 1'b0;
         product_q      <= 1'b0;
         change_valid_q <= 1'b0;
         change_value_q <= '0;
         coin_reject_q  <= 1'b0;
         deny_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         busy_q         <= busy_d;
         product_q      <= product_d;
         change_valid_q <= change_valid_d;
         change_value_q <= change_value_d;
         coin_reject_q  <= coin_reject_d;
         deny_q         <= deny_d;
      end
   end

   dispenser_stage_seq #(
      .NUM_STAGES  (NUM_STAGES),
      .STAGE_TICKS (STAGE_TICKS)
   ) u_stage_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (seq_start),
      .tick     (bus.tick),
      .mask_in  (sel_recipe),
      .stage_on (bus.stage_on),
      .done     (seq_done)
   );

   assign bus.credit       = credit_q;
   assign bus.busy         = busy_q;
   assign bus.product      = product_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_value = change_value_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.deny         = deny_q;
   assign bus.state_o      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_drink_dispenser_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_drink_dispenser_ctrl : directed vectors, cycle model plus literal pins
// Revision                : 1.0
// ---------------------------------------------------------------------------
module tb_drink_dispenser_ctrl;
   localparam int ND = 4;
   localparam int NS = 5;
   localparam int CW = 8;
   localparam int ST = 2;
   localparam int SW = $clog2(ND);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   drink_dispenser_ctrl_if #(.NUM_DRINKS(ND), .NUM_STAGES(NS), .CREDIT_W(CW)) bus ();

   drink_dispenser_ctrl #(
      .NUM_DRINKS(ND), .NUM_STAGES(NS), .CREDIT_W(CW), .STAGE_TICKS(ST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned prices [ND] = '{3, 4, 5, 7};
   int unsigned recipes[ND] = '{5'b00001, 5'b00011, 5'b00111, 5'b11111};

   // Behavioural model: credit as an integer, dispense as (stage, ticks seen).
   int          m_state = 0, m_credit = 0, m_stage = 0, m_ticks = 0;
   int unsigned m_mask = 0;
   int unsigned e_stage_on = 0, e_cval = 0;
   bit          e_busy = 0, e_product = 0, e_cv = 0, e_rej = 0, e_deny = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  id;
      bit  fin;
      e_product = 0; e_cv = 0; e_cval = 0; e_rej = 0; e_deny = 0;
      if (rst) begin
         m_state = 0; m_credit = 0; m_stage = 0; m_ticks = 0; m_mask = 0;
      end else begin
         case (m_state)
            0: begin
               if (bus.cancel) begin
                  e_rej = bus.coin_valid;
                  if (m_credit > 0) begin
                     e_cv = 1; e_cval = m_credit; m_credit = 0; m_state = 3;
                  end
               end else if (bus.select_valid) begin
                  e_rej = bus.coin_valid;
                  id = int'(bus.select_id);
                  if (id >= ND || m_credit < int'(prices[id]) || recipes[id] == 0) e_deny = 1;
                  else begin
                     m_credit -= prices[id]; m_mask = recipes[id];
                     m_stage = 0; m_ticks = 0; m_state = 1;
                  end
               end else if (bus.coin_valid) begin
                  if (m_credit + int'(bus.coin_value) > (1 << CW) - 1) e_rej = 1;
                  else m_credit += bus.coin_value;
               end
            end
            1: begin
               e_rej = bus.coin_valid;
               fin = 0;
               if (((m_mask >> m_stage) & 1) != 0) begin
                  if (bus.tick) m_ticks++;
                  fin = (m_ticks == ST);
               end else fin = 1;
               if (fin) begin
                  m_stage++; m_ticks = 0;
                  if (m_stage == NS) begin
                     m_state = 2; e_product = 1;
                     if (m_credit > 0) begin e_cv = 1; e_cval = m_credit; m_credit = 0; end
                  end
               end
            end
            default: begin
               e_rej = bus.coin_valid; m_state = 0;
            end
         endcase
      end
      e_stage_on = (m_state == 1 && ((m_mask >> m_stage) & 1) != 0) ? (32'd1 << m_stage) : 0;
      e_busy = (m_state == 1 || m_state == 2);
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("state_o", bus.state_o, m_state);
      chk("credit", bus.credit, m_credit);
      chk("stage_on", bus.stage_on, e_stage_on);
      chk("busy", bus.busy, e_busy);
      chk("product", bus.product, e_product);
      chk("change_valid", bus.change_valid, e_cv);
      chk("change_value", bus.change_value, e_cval);
      chk("coin_reject", bus.coin_reject, e_rej);
      chk("deny", bus.deny, e_deny);
   end

   task automatic apply_tables();
      for (int i = 0; i < ND; i++) begin
         bus.price[i*CW +: CW]  = CW'(prices[i]);
         bus.recipe[i*NS +: NS] = NS'(recipes[i]);
      end
   endtask

   // One-cycle request: driven at negedge, sampled at posedge, cleared after it.
   task automatic cyc(input bit cv, input int cval, input bit sv, input int sid,
                      input bit can, input bit tk);
      @(negedge clk);
      bus.coin_valid = cv; bus.coin_value = CW'(cval);
      bus.select_valid = sv; bus.select_id = SW'(sid);
      bus.cancel = can; bus.tick = tk;
      @(posedge clk);
      #2;
      bus.coin_valid = 0; bus.coin_value = '0; bus.select_valid = 0;
      bus.select_id = '0; bus.cancel = 0; bus.tick = 0;
   endtask

   int n_prod, n_cv, prod_cval, prod_credit, n_s0, n_s1;

   task automatic run(input int n);
      n_prod = 0; n_cv = 0; prod_cval = -1; prod_credit = -1; n_s0 = 0; n_s1 = 0;
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 0, 0, 0, (i % 3) == 2);
         if (bus.product) begin
            n_prod++; prod_cval = bus.change_value; prod_credit = bus.credit;
         end
         if (bus.change_valid) n_cv++;
         if (bus.stage_on == 5'b00001) n_s0++;
         if (bus.stage_on == 5'b00010) n_s1++;
      end
   endtask

   initial begin
      bus.coin_valid = 0; bus.coin_value = '0; bus.select_valid = 0;
      bus.select_id = '0; bus.cancel = 0; bus.tick = 0;
      apply_tables();
      rst = 1;
      @(posedge clk); #2;
      chk("reset credit", bus.credit, 0);
      chk("reset state", bus.state_o, 0);
      chk("reset stage_on", bus.stage_on, 0);
      @(negedge clk); rst = 0;

      // Drink 1: exact credit, two enabled stages, no change.
      cyc(1, 2, 0, 0, 0, 0);
      cyc(1, 2, 0, 0, 0, 0);
      chk("s1 credit 4", bus.credit, 4);
      cyc(0, 0, 1, 1, 0, 1);
      chk("s1 accept credit", bus.credit, 0);
      chk("s1 first stage", bus.stage_on, 5'b00001);
      chk("s1 busy", bus.busy, 1);
      run(40);
      chk("s1 stage0 cycles", n_s0, 5);
      chk("s1 stage1 cycles", n_s1, 6);
      chk("s1 product count", n_prod, 1);
      chk("s1 change count", n_cv, 0);

      // Drink 0: change 7 returned together with product.
      cyc(1, 5, 0, 0, 0, 0);
      cyc(1, 5, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("s2 credit after accept", bus.credit, 7);
      run(40);
      chk("s2 product count", n_prod, 1);
      chk("s2 change at product", prod_cval, 7);
      chk("s2 credit at product", prod_credit, 0);

      // Deny for insufficient credit, refund, empty cancel.
      cyc(1, 3, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 0, 0);
      chk("s3 deny", bus.deny, 1);
      chk("s3 credit kept", bus.credit, 3);
      cyc(0, 0, 0, 0, 1, 0);
      chk("s3 refund valid", bus.change_valid, 1);
      chk("s3 refund value", bus.change_value, 3);
      chk("s3 refund state", bus.state_o, 3);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("s3 empty cancel", bus.change_valid, 0);
      chk("s3 empty cancel state", bus.state_o, 0);

      // Overflow reject, coin dropped by select priority, coin while busy.
      cyc(1, 200, 0, 0, 0, 0);
      cyc(1, 50, 0, 0, 0, 0);
      cyc(1, 10, 0, 0, 0, 0);
      chk("s4 overflow reject", bus.coin_reject, 1);
      chk("s4 credit 250", bus.credit, 250);
      cyc(1, 1, 1, 0, 0, 0);
      chk("s4 coin+select reject", bus.coin_reject, 1);
      chk("s4 coin+select credit", bus.credit, 247);
      cyc(1, 5, 0, 0, 0, 0);
      chk("s4 busy reject", bus.coin_reject, 1);
      run(40);
      chk("s4 change at product", prod_cval, 247);

      // Empty recipe denied; reset while stage 2 is on.
      recipes[3] = 0; apply_tables();
      cyc(1, 8, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 0, 0);
      chk("s5 empty recipe deny", bus.deny, 1);
      recipes[3] = 5'b11111; apply_tables();
      cyc(0, 0, 1, 3, 0, 0);
      chk("s5 accept credit", bus.credit, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
      chk("s5 stage2 on", bus.stage_on, 5'b00100);
      @(negedge clk); rst = 1;
      @(posedge clk); #2;
      chk("s5 reset credit", bus.credit, 0);
      chk("s5 reset stage_on", bus.stage_on, 0);
      chk("s5 reset busy", bus.busy, 0);
      chk("s5 reset change", bus.change_valid, 0);
      @(negedge clk); rst = 0;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
